// File: rtl/tile_scheduler_pkg.sv
// rtl/tile_scheduler_pkg.sv - shared state type and width defaults for the tile scheduler
package tile_sched_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int TMO_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ROUTE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5,
    ST_ABORT = 3'd6
  } tile_sched_state_t;

endpackage

// File: rtl/tile_scheduler_if.sv
// rtl/tile_scheduler_if.sv - host/CSR and core-control signal bundle of the tile scheduler
interface tile_scheduler_if import tile_sched_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int TMO_WIDTH  = TMO_WIDTH_DEF
);
  logic                  i_start;
  logic                  i_abort;
  logic [CNT_WIDTH-1:0]  i_cfg_sp_tiles;
  logic [CNT_WIDTH-1:0]  i_cfg_ch_tiles;
  logic [ADDR_WIDTH-1:0] i_cfg_route_size;
  logic [TMO_WIDTH-1:0]  i_cfg_timeout;
  logic                  i_core_done;
  logic                  o_reg_clear;
  logic                  o_route_en;
  logic [ADDR_WIDTH-1:0] o_route_size;
  logic [CNT_WIDTH-1:0]  o_sp_idx;
  logic [CNT_WIDTH-1:0]  o_ch_idx;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_tmo_err;

  modport master (
    output i_start, i_abort, i_cfg_sp_tiles, i_cfg_ch_tiles, i_cfg_route_size,
           i_cfg_timeout, i_core_done,
    input  o_reg_clear, o_route_en, o_route_size, o_sp_idx, o_ch_idx, o_busy,
           o_done, o_tmo_err
  );

  modport slave (
    input  i_start, i_abort, i_cfg_sp_tiles, i_cfg_ch_tiles, i_cfg_route_size,
           i_cfg_timeout, i_core_done,
    output o_reg_clear, o_route_en, o_route_size, o_sp_idx, o_ch_idx, o_busy,
           o_done, o_tmo_err
  );

endinterface

// File: rtl/tile_scheduler_index_counter.sv
// rtl/tile_scheduler_index_counter.sv - two-level nested tile index counter (inner wraps into outer)
module tile_index_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] max_inner,
  input  logic [CNT_WIDTH-1:0] max_outer,
  output logic [CNT_WIDTH-1:0] idx_inner,
  output logic [CNT_WIDTH-1:0] idx_outer,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] inner_q, inner_d;
  logic [CNT_WIDTH-1:0] outer_q, outer_d;

  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr) begin
      inner_d = '0;
      outer_d = '0;
    end else if (en) begin
      if (inner_q == max_inner) begin
        inner_d = '0;
        // Outer saturates at its max so the index never runs past the last tile
        if (outer_q != max_outer) outer_d = outer_q + CNT_WIDTH'(1);
      end else begin
        inner_d = inner_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign idx_inner = inner_q;
  assign idx_outer = outer_q;
  assign last      = (inner_q == max_inner) && (outer_q == max_outer);

endmodule

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - sequences the compute core over spatial x channel tiles of one layer
module tile_scheduler import tile_sched_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int TMO_WIDTH  = TMO_WIDTH_DEF
) (
  input logic              i_clk,
  input logic              i_nrst,
  tile_scheduler_if.slave  bus
);

  tile_sched_state_t     state_q, state_d;
  logic [CNT_WIDTH-1:0]  sp_tiles_q, sp_tiles_d;
  logic [CNT_WIDTH-1:0]  ch_tiles_q, ch_tiles_d;
  logic [ADDR_WIDTH-1:0] route_size_q, route_size_d;
  logic [TMO_WIDTH-1:0]  timeout_q, timeout_d;
  logic [TMO_WIDTH-1:0]  wd_cnt_q, wd_cnt_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  reg_clear_q, reg_clear_d;
  logic                  route_en_q, route_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  idx_en;
  logic                  idx_clr;
  logic                  idx_last;
  logic [CNT_WIDTH-1:0]  sp_idx;
  logic [CNT_WIDTH-1:0]  ch_idx;

  tile_index_counter #(.CNT_WIDTH(CNT_WIDTH)) u_idx (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .en        (idx_en),
    .clr       (idx_clr),
    .max_inner (ch_tiles_q - CNT_WIDTH'(1)),
    .max_outer (sp_tiles_q - CNT_WIDTH'(1)),
    .idx_inner (ch_idx),
    .idx_outer (sp_idx),
    .last      (idx_last)
  );

  always_comb begin
    state_d      = state_q;
    sp_tiles_d   = sp_tiles_q;
    ch_tiles_d   = ch_tiles_q;
    route_size_d = route_size_q;
    timeout_d    = timeout_q;
    wd_cnt_d     = wd_cnt_q;
    tmo_err_d    = tmo_err_q;
    idx_en       = 1'b0;
    idx_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          sp_tiles_d   = bus.i_cfg_sp_tiles;
          ch_tiles_d   = bus.i_cfg_ch_tiles;
          route_size_d = bus.i_cfg_route_size;
          timeout_d    = bus.i_cfg_timeout;
          tmo_err_d    = 1'b0;
          idx_clr      = 1'b1;
          state_d      = (bus.i_cfg_sp_tiles == '0 || bus.i_cfg_ch_tiles == '0)
                         ? ST_FIN : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = bus.i_abort ? ST_ABORT : ST_ROUTE;
      ST_ROUTE: begin
        wd_cnt_d = '0;
        state_d  = bus.i_abort ? ST_ABORT : ST_WAIT;
      end
      ST_WAIT: begin
        // Abort outranks a same-cycle core done or watchdog expiry
        if (bus.i_abort) begin
          state_d = ST_ABORT;
        end else if (bus.i_core_done) begin
          state_d = ST_NEXT;
        end else begin
          wd_cnt_d = wd_cnt_q + TMO_WIDTH'(1);
          if (timeout_q != '0 && wd_cnt_q == timeout_q - TMO_WIDTH'(1)) begin
            tmo_err_d = 1'b1;
            state_d   = ST_ABORT;
          end
        end
      end
      ST_NEXT: begin
        if (bus.i_abort) begin
          state_d = ST_ABORT;
        end else if (idx_last) begin
          state_d = ST_FIN;
        end else begin
          idx_en  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    reg_clear_d = (state_d == ST_CLEAR) || (state_d == ST_ABORT);
    route_en_d  = (state_d == ST_ROUTE);
    done_d      = (state_d == ST_FIN);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= ST_IDLE;
      sp_tiles_q   <= '0;
      ch_tiles_q   <= '0;
      route_size_q <= '0;
      timeout_q    <= '0;
      wd_cnt_q     <= '0;
      tmo_err_q    <= 1'b0;
      reg_clear_q  <= 1'b0;
      route_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_tiles_q   <= sp_tiles_d;
      ch_tiles_q   <= ch_tiles_d;
      route_size_q <= route_size_d;
      timeout_q    <= timeout_d;
      wd_cnt_q     <= wd_cnt_d;
      tmo_err_q    <= tmo_err_d;
      reg_clear_q  <= reg_clear_d;
      route_en_q   <= route_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_reg_clear  = reg_clear_q;
  assign bus.o_route_en   = route_en_q;
  assign bus.o_route_size = route_size_q;
  assign bus.o_sp_idx     = sp_idx;
  assign bus.o_ch_idx     = ch_idx;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - randomized scoreboard bench for tile_scheduler
module tb_tile_scheduler;

  localparam int K_CLR   = 0;
  localparam int K_ROUTE = 1;
  localparam int K_DONE  = 2;
  localparam int K_TMO   = 3;

  typedef struct {
    int kind;
    int sp;
    int ch;
    int val;
  } ev_t;

  logic clk;
  logic nrst;

  tile_scheduler_if bus ();

  tile_scheduler dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_route = 0;
  bit  prev_tmo = 0;
  int  core_mode = 0;
  int  core_delay = 5;
  bit  hold_start = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int sp, input int ch, input int val);
    ev_t e;
    e.kind = kind; e.sp = sp; e.ch = ch; e.val = val;
    exp_q.push_back(e);
  endtask

  // Reference: every tile in channel-inner order gets a clear then a route, then one done
  task automatic model_layer(input int s_n, input int c_n, input int size);
    for (int s = 0; s < s_n; s++)
      for (int c = 0; c < c_n; c++) begin
        push_ev(K_CLR, s, c, 0);
        push_ev(K_ROUTE, s, c, size);
      end
    if (s_n == 0 || c_n == 0) push_ev(K_DONE, 0, 0, 0);
    else                      push_ev(K_DONE, s_n - 1, c_n - 1, 0);
  endtask

  task automatic pop_ev(input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.sp = 0; e.ch = 0; e.val = 0;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: got event expected none (t=%0t)", name, $time);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Core model: raise done core_delay cycles after each route enable (mode 0), never (mode 1),
  // or leave i_core_done to the stimulus (mode 2)
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (core_mode != 2) begin
        if (bus.o_route_en) begin
          bus.i_core_done = 1'b0;
          cnt = core_delay;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && core_mode == 0) bus.i_core_done = 1'b1;
        end
      end
    end
  end

  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        prev_tmo = 1'b0;
      end else begin
        if (bus.o_tmo_err && !prev_tmo) begin
          pop_ev("tmo", e, ok);
          if (ok) begin
            chk("tmo_kind", K_TMO, e.kind);
            chk("tmo_latency", cyc - last_route, e.val);
          end
        end
        prev_tmo = bus.o_tmo_err;
        if (bus.o_reg_clear) begin
          pop_ev("clear", e, ok);
          if (ok) begin
            chk("clear_kind", K_CLR, e.kind);
            if (e.sp >= 0) begin
              chk("clear_sp_idx", bus.o_sp_idx, e.sp);
              chk("clear_ch_idx", bus.o_ch_idx, e.ch);
            end
          end
        end
        if (bus.o_route_en) begin
          last_route = cyc;
          pop_ev("route", e, ok);
          if (ok) begin
            chk("route_kind", K_ROUTE, e.kind);
            chk("route_sp_idx", bus.o_sp_idx, e.sp);
            chk("route_ch_idx", bus.o_ch_idx, e.ch);
            chk("route_size", bus.o_route_size, e.val);
          end
        end
        if (bus.o_done) begin
          pop_ev("done", e, ok);
          if (ok) begin
            chk("done_kind", K_DONE, e.kind);
            chk("done_sp_idx", bus.o_sp_idx, e.sp);
            chk("done_ch_idx", bus.o_ch_idx, e.ch);
          end
        end
      end
    end
  end

  task automatic start_layer(input int s_n, input int c_n, input int size, input int tmo);
    @(negedge clk);
    bus.i_cfg_sp_tiles   = 8'(s_n);
    bus.i_cfg_ch_tiles   = 8'(c_n);
    bus.i_cfg_route_size = 8'(size);
    bus.i_cfg_timeout    = 16'(tmo);
    bus.i_abort          = 1'b0;
    bus.i_start          = 1'b1;
    @(negedge clk);
    if (!hold_start) bus.i_start = 1'b0;
    chk("start_busy", bus.o_busy, 1);
    chk("start_tmo_cleared", bus.o_tmo_err, 0);
    if (s_n == 0 || c_n == 0) begin
      chk("zero_done_latency", bus.o_done, 1);
      chk("zero_no_clear", bus.o_reg_clear, 0);
    end else begin
      chk("clear_latency", bus.o_reg_clear, 1);
      chk("no_early_done", bus.o_done, 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.o_busy && n < budget) begin
      if (hold_start) begin
        bus.i_cfg_sp_tiles   = 8'($urandom_range(0, 5));
        bus.i_cfg_ch_tiles   = 8'($urandom_range(0, 5));
        bus.i_cfg_route_size = 8'($urandom_range(0, 255));
        bus.i_cfg_timeout    = 16'($urandom_range(1, 2));
        if (bus.o_done) bus.i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("busy_drops_in_budget", bus.o_busy, 0);
  endtask

  initial begin
    int seen;
    int n;
    int s_n, c_n, sz, tmo;

    nrst                 = 1'b0;
    bus.i_start          = 1'b0;
    bus.i_abort          = 1'b0;
    bus.i_cfg_sp_tiles   = '0;
    bus.i_cfg_ch_tiles   = '0;
    bus.i_cfg_route_size = '0;
    bus.i_cfg_timeout    = '0;
    bus.i_core_done      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.o_reg_clear, bus.o_route_en, bus.o_route_size, bus.o_sp_idx,
                          bus.o_ch_idx, bus.o_busy, bus.o_done, bus.o_tmo_err}, 0);
    nrst = 1'b1;

    // Reference layer: 2 spatial x 3 channel tiles
    core_mode = 0; core_delay = 5;
    model_layer(2, 3, 16);
    start_layer(2, 3, 16, 0);
    wait_idle(500);
    chk("layer_drain", exp_q.size(), 0);

    // Zero spatial tiles: straight to done, busy for a single cycle
    model_layer(0, 3, 9);
    start_layer(0, 3, 9, 0);
    @(negedge clk);
    chk("zero_busy_one_cycle", bus.o_busy, 0);
    chk("zero_drain", exp_q.size(), 0);

    // Watchdog: 10 WAIT cycles without core done, error seen the cycle after
    core_mode = 1;
    push_ev(K_CLR, 0, 0, 0);
    push_ev(K_ROUTE, 0, 0, 16);
    push_ev(K_TMO, 0, 0, 10 + 1);
    push_ev(K_CLR, -1, -1, 0);
    start_layer(2, 3, 16, 10);
    wait_idle(500);
    chk("tmo_drain", exp_q.size(), 0);
    chk("tmo_sticky", bus.o_tmo_err, 1);

    // Abort together with core done in the first WAIT cycle
    core_mode = 2;
    bus.i_core_done = 1'b0;
    push_ev(K_CLR, 0, 0, 0);
    push_ev(K_ROUTE, 0, 0, 20);
    push_ev(K_CLR, -1, -1, 0);
    start_layer(1, 2, 20, 0);
    n = 0;
    while (!bus.o_route_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_route_seen", bus.o_route_en, 1);
    @(negedge clk);
    bus.i_core_done = 1'b1;
    bus.i_abort     = 1'b1;
    @(negedge clk);
    bus.i_core_done = 1'b0;
    bus.i_abort     = 1'b0;
    wait_idle(100);
    chk("abort_drain", exp_q.size(), 0);

    // Reset in the WAIT of the third tile, then a clean rerun
    core_mode = 0; core_delay = 8;
    for (int c = 0; c < 3; c++) begin
      push_ev(K_CLR, 0, c, 0);
      push_ev(K_ROUTE, 0, c, 7);
    end
    start_layer(2, 3, 7, 0);
    seen = 0; n = 0;
    while (seen < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.o_route_en) seen++;
    end
    chk("reset_third_route_seen", seen, 3);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1 chk("midlayer_reset_outputs", {bus.o_reg_clear, bus.o_route_en, bus.o_route_size,
                                      bus.o_sp_idx, bus.o_ch_idx, bus.o_busy, bus.o_done,
                                      bus.o_tmo_err}, 0);
    chk("reset_drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    model_layer(2, 3, 7);
    start_layer(2, 3, 7, 0);
    wait_idle(500);
    chk("rerun_drain", exp_q.size(), 0);

    // Start held high across the layer while cfg churns
    hold_start = 1'b1; core_delay = 3;
    model_layer(2, 2, 33);
    start_layer(2, 2, 33, 0);
    wait_idle(500);
    hold_start  = 1'b0;
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_single_layer", bus.o_busy, 0);
    chk("hold_drain", exp_q.size(), 0);

    // Random layers; a nonzero watchdog is never shorter than the core latency
    for (int it = 0; it < 10; it++) begin
      s_n = $urandom_range(0, 3);
      c_n = $urandom_range(0, 3);
      sz  = $urandom_range(0, 255);
      core_delay = $urandom_range(1, 6);
      tmo = ($urandom_range(0, 1) == 0) ? 0 : core_delay + $urandom_range(0, 3);
      model_layer(s_n, c_n, sz);
      start_layer(s_n, c_n, sz, tmo);
      wait_idle(1000);
      chk("rand_drain", exp_q.size(), 0);
      exp_q.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
